// File: rtl/keypad_label_display.sv
// keypad_label_display: scans the scrambled keypad label map onto muxed 7-seg digits.
// Optional decimal-point marker for a pressed position: define KEYPAD_DISPLAY_DP_EN.
module keypad_label_display #(
  parameter int NUM_DIGITS   = 10,
  parameter int DWELL_CYCLES = 1000,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] map_i,
  input  logic                    map_valid_i,
  output logic                    map_ready_o,
  input  logic                    blank_i,
`ifdef KEYPAD_DISPLAY_DP_EN
  input  logic                    press_valid_i,
  input  logic [3:0]              press_index_i,
  output logic                    dp_o,
`endif
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   dig_sel_o,
  output logic                    frame_done_o
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [15:0] DW_LAST = 16'(DWELL_CYCLES - 1);
  localparam logic [15:0] GP_LAST =
    (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] ONE =
    {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_OFF,
    S_DWELL,
    S_GAP
  } state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [15:0]             cnt;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pending_full;

  logic                    accept;
  logic                    dwell_last;
  logic                    gap_last;
  logic                    step_end;
  logic                    boundary;
  logic                    commit;
  logic                    dwell_nxt;
  logic                    pend_nxt;
  logic [IW-1:0]           nidx;
  logic [IW-1:0]           sidx;
  logic [4*NUM_DIGITS-1:0] src_map;
  logic [NUM_DIGITS-1:0]   sel_one;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h40;
    endcase
  endfunction

  assign accept = map_valid_i && map_ready_o;

  // Look ahead: will the next cycle be a DWELL, which digit, from which map.
  always_comb begin
    dwell_last = (cnt == DW_LAST);
    gap_last   = (cnt == GP_LAST);
    step_end   = 1'b0;
    dwell_nxt  = 1'b0;
    sidx       = idx;
    unique case (state)
      S_OFF: begin
        dwell_nxt = accept;
        sidx      = '0;
      end
      S_DWELL: begin
        step_end  = dwell_last && (GAP_CYCLES == 0);
        dwell_nxt = !(dwell_last && (GAP_CYCLES != 0));
      end
      S_GAP: begin
        step_end  = gap_last;
        dwell_nxt = gap_last;
      end
      default: ;
    endcase
    boundary = step_end && (idx == LAST);
    nidx     = boundary ? '0 : idx + IW'(1);
    if (step_end) sidx = nidx;
    commit   = boundary && pending_full;
    pend_nxt = pending_full;
    if (state != S_OFF) begin
      if (commit)      pend_nxt = 1'b0;
      else if (accept) pend_nxt = 1'b1;
    end
    if (state == S_OFF) src_map = map_i;
    else if (commit)    src_map = pending;
    else                src_map = active;
    sel_one = ONE << sidx;
  end

  // Scan FSM, map double-buffer and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_OFF;
      idx          <= '0;
      cnt          <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      map_ready_o  <= 1'b1;
      seg_o        <= '0;
      dig_sel_o    <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= boundary;
      pending_full <= pend_nxt;
      map_ready_o  <= !pend_nxt;
      seg_o        <= dwell_nxt ? enc(src_map[{sidx, 2'b00} +: 4]) : 7'h00;
      dig_sel_o    <= (dwell_nxt && !blank_i) ? sel_one : '0;
      if (state == S_OFF) begin
        if (accept) active <= map_i;
      end else if (commit) begin
        active <= pending;
      end else if (accept) begin
        pending <= map_i;
      end
      unique case (state)
        S_OFF: begin
          if (accept) begin
            state <= S_DWELL;
            idx   <= '0;
            cnt   <= '0;
          end
        end
        S_DWELL: begin
          if (dwell_last) begin
            cnt <= '0;
            if (GAP_CYCLES == 0) idx   <= nidx;
            else                 state <= S_GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (gap_last) begin
            state <= S_DWELL;
            idx   <= nidx;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_OFF;
      endcase
    end
  end

`ifdef KEYPAD_DISPLAY_DP_EN
  logic       dp_armed;
  logic [3:0] dp_idx;
  logic [1:0] dp_left;

  // Mark the pressed position for the rest of this frame plus two full frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_armed <= 1'b0;
      dp_idx   <= '0;
      dp_left  <= '0;
      dp_o     <= 1'b0;
    end else begin
      if (press_valid_i && (32'(press_index_i) < NUM_DIGITS)) begin
        dp_armed <= 1'b1;
        dp_idx   <= press_index_i;
        dp_left  <= 2'd3;
      end else if (boundary && dp_armed) begin
        dp_left <= dp_left - 2'd1;
        if (dp_left == 2'd1) dp_armed <= 1'b0;
      end
      dp_o <= dp_armed && dwell_nxt && !blank_i &&
              (32'(sidx) == 32'(dp_idx));
    end
  end
`endif

endmodule

// File: tb/tb_keypad_label_display.sv
// tb_keypad_label_display: directed checks of scan timing, map commit and blanking.
// Two instances: DWELL=4/GAP=1 and DWELL=1/GAP=0 share all inputs.
module tb_keypad_label_display;

  localparam int N = 10;
  localparam logic [39:0] MAP_A = 40'h9876543210;
  localparam logic [39:0] MAP_B = 40'h0123456789;
  localparam logic [39:0] MAP_C = 40'h987654C210;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         map_valid = 1'b0;
  logic         blank = 1'b0;
  logic [39:0]  map = '0;
  logic         map_ready, map_ready2;
  logic         frame_done, frame_done2;
  logic [6:0]   seg, seg2;
  logic [N-1:0] sel, sel2;
`ifdef KEYPAD_DISPLAY_DP_EN
  logic         press_valid = 1'b0;
  logic [3:0]   press_index = '0;
  logic         dp, dp2;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  keypad_label_display #(
    .NUM_DIGITS(N), .DWELL_CYCLES(4), .GAP_CYCLES(1)
  ) u_dut (
    .clk(clk), .rst(rst),
    .map_i(map), .map_valid_i(map_valid),
    .map_ready_o(map_ready), .blank_i(blank),
`ifdef KEYPAD_DISPLAY_DP_EN
    .press_valid_i(press_valid), .press_index_i(press_index),
    .dp_o(dp),
`endif
    .seg_o(seg), .dig_sel_o(sel), .frame_done_o(frame_done)
  );

  keypad_label_display #(
    .NUM_DIGITS(N), .DWELL_CYCLES(1), .GAP_CYCLES(0)
  ) u_fast (
    .clk(clk), .rst(rst),
    .map_i(map), .map_valid_i(map_valid),
    .map_ready_o(map_ready2), .blank_i(blank),
`ifdef KEYPAD_DISPLAY_DP_EN
    .press_valid_i(press_valid), .press_index_i(press_index),
    .dp_o(dp2),
`endif
    .seg_o(seg2), .dig_sel_o(sel2), .frame_done_o(frame_done2)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h",
                  tag, $time, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [39:0] cur;
    logic [9:0]  e_sel;
    logic [6:0]  e_seg;
    logic        e_rdy;
    int          rel, d, ph;

    repeat (3) step();
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_rdy", 32'(map_ready), 32'h1);
    rst = 1'b0;
    map = MAP_A;
    map_valid = 1'b1;

    for (int t = 1; t <= 210; t++) begin
      step();
      rel = (t - 1) % 50;
      d   = rel / 5;
      ph  = rel % 5;
      cur = (t <= 100) ? MAP_A : (t <= 150) ? MAP_B : MAP_C;
      e_sel = (ph < 4) ? (10'b1 << d) : 10'b0;
      if (t >= 176 && t <= 182) e_sel = '0;
      e_seg = (ph < 4) ? seg_of(cur[4*d +: 4]) : 7'h00;
      e_rdy = !((t >= 61 && t <= 100) || (t >= 102 && t <= 150) ||
                (t >= 206));
      chk("sel", 32'(sel), 32'(e_sel));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("fd", 32'(frame_done), 32'((t % 50 == 1) && (t >= 51)));
      chk("rdy", 32'(map_ready), 32'(e_rdy));
      if (t <= 50) begin
        d = (t - 1) % 10;
        chk("fast_sel", 32'(sel2), 32'(10'b1 << d));
        chk("fast_seg", 32'(seg2), 32'(seg_of(MAP_A[4*d +: 4])));
        chk("fast_fd", 32'(frame_done2),
            32'((t % 10 == 1) && (t >= 11)));
        chk("fast_rdy", 32'(map_ready2), 32'h1);
      end
      if (t == 1)   map_valid = 1'b0;
      if (t == 60) begin
        map = MAP_B;
        map_valid = 1'b1;
      end
      if (t == 61)  map = MAP_C;
      if (t == 102) map_valid = 1'b0;
      if (t == 175) blank = 1'b1;
      if (t == 182) blank = 1'b0;
      if (t == 205) begin
        map = MAP_A;
        map_valid = 1'b1;
      end
      if (t == 206) map_valid = 1'b0;
    end

    rst = 1'b1;
    step();
    chk("rst2_seg", 32'(seg), 32'h0);
    chk("rst2_sel", 32'(sel), 32'h0);
    chk("rst2_fd", 32'(frame_done), 32'h0);
    chk("rst2_rdy", 32'(map_ready), 32'h1);
    rst = 1'b0;
    repeat (8) begin
      step();
      chk("off_sel", 32'(sel), 32'h0);
      chk("off_seg", 32'(seg), 32'h0);
      chk("off_rdy", 32'(map_ready), 32'h1);
    end
    map = MAP_B;
    map_valid = 1'b1;
    step();
    chk("re_sel", 32'(sel), 32'h001);
    chk("re_seg", 32'(seg), 32'h6F);
    chk("re_rdy", 32'(map_ready), 32'h1);
    map_valid = 1'b0;
    repeat (3) begin
      step();
      chk("re_dwell", 32'(sel), 32'h001);
    end
    step();
    chk("re_gap", 32'(sel), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
